// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU. It takes a 4-bit ALU control code and two XLEN-bit
//   operands and returns a registered result. Both sides use valid/ready
//   handshakes. Logic and arithmetic ops finish in one cycle. Shifts move one
//   bit per cycle under a small FSM.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    request valid
//   in_ready    unit can accept a request this cycle (combinational)
//   alucontrol  operation code
//   operand_a   first operand / shift source
//   operand_b   second operand / shift amount in [SHW-1:0]
//   out_valid   result valid
//   out_ready   consumer accepts result
//   result      registered result
//   zero        registered (result == 0)
//   illegal     registered; alucontrol code not supported
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | empty, ready for a request
// SHIFT | iterative shift in progress; cnt holds the remaining bits
// DONE  | result presented, held until out_ready

module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucontrol,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_t;

    state_t          state, state_nxt;
    shift_t          sh_kind, sh_kind_dec;
    logic [XLEN-1:0] acc, acc_shifted;
    logic [SHW-1:0]  cnt;
    logic            accept;
    logic            cnt_done;

    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;
    logic            is_shift;
    logic            slt_bit;
    logic            sltu_bit;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign cnt_done  = (cnt == '0);

    assign slt_bit  = $signed(operand_a) < $signed(operand_b);
    assign sltu_bit = operand_a < operand_b;

    // Single-cycle datapath and opcode classification.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        is_shift    = 1'b0;
        sh_kind_dec = SH_SLL;
        case (alucontrol)
            4'b0000: alu_res = operand_a & operand_b;
            4'b0001: alu_res = operand_a | operand_b;
            4'b0010: alu_res = operand_a + operand_b;
            4'b0110: alu_res = operand_a - operand_b;
            4'b0011: alu_res = operand_a ^ operand_b;
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, sltu_bit};
            4'b0100: begin
                is_shift    = 1'b1;
                sh_kind_dec = SH_SLL;
            end
            4'b0101: begin
                is_shift    = 1'b1;
                sh_kind_dec = SH_SRL;
            end
            4'b1000: begin
                is_shift    = 1'b1;
                sh_kind_dec = SH_SRA;
            end
            default: alu_illegal = 1'b1;
        endcase
    end

    // One-bit shift of the accumulator.
    always_comb begin
        acc_shifted = acc;
        case (sh_kind)
            SH_SLL:  acc_shifted = {acc[XLEN-2:0], 1'b0};
            SH_SRL:  acc_shifted = {1'b0, acc[XLEN-1:1]};
            SH_SRA:  acc_shifted = {acc[XLEN-1], acc[XLEN-1:1]};
            default: acc_shifted = acc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = is_shift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt_done) state_nxt = DONE;
            end
            DONE: begin
                // A back-to-back accept takes priority over returning to IDLE.
                if (accept)         state_nxt = is_shift ? SHIFT : DONE;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sh_kind <= SH_SLL;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            if (is_shift) begin
                acc     <= operand_a;
                cnt     <= operand_b[SHW-1:0];
                sh_kind <= sh_kind_dec;
            end else begin
                result  <= alu_res;
                zero    <= (alu_res == '0);
                illegal <= alu_illegal;
            end
        end else if (state == SHIFT) begin
            if (cnt_done) begin
                result  <= acc;
                zero    <= (acc == '0);
                illegal <= 1'b0;
            end else begin
                acc <= acc_shifted;
                cnt <= cnt - SHW'(1);
            end
        end
    end

endmodule
